// File: rtl/layer_pkg.sv
// Shared constants for the layer command receiver: command codes, load type codes,
// the type-to-buffer-select table and the one-hot state encoding.
package layer_pkg;

    localparam logic [3:0] CMD_LOAD = 4'h1;
    localparam logic [3:0] CMD_READ = 4'h2;
    localparam logic [3:0] CMD_CONV = 4'h4;

    localparam logic [3:0] TYPE_BIAS    = 4'd2;
    localparam logic [3:0] TYPE_LEAKY   = 4'd3;
    localparam logic [3:0] TYPE_FEATURE = 4'd4;
    localparam logic [3:0] TYPE_WEIGHT  = 4'd5;

    // Load type owning each bit of buf_wr_sel: [0] bias, [1] leakyrelu, [2] weight, [3] feature
    localparam logic [3:0] SEL_TYPE [4] = '{TYPE_BIAS, TYPE_LEAKY, TYPE_WEIGHT, TYPE_FEATURE};

    localparam logic [4:0] S_IDLE = 5'h01;
    localparam logic [4:0] S_LOAD = 5'h02;
    localparam logic [4:0] S_CONV = 5'h04;
    localparam logic [4:0] S_READ = 5'h08;
    localparam logic [4:0] S_DONE = 5'h10;

    typedef enum logic [4:0] {
        ST_IDLE = S_IDLE,
        ST_LOAD = S_LOAD,
        ST_CONV = S_CONV,
        ST_READ = S_READ,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/layer_cmd_rx_wr.sv
// Stream-to-buffer write stage: per-load beat counter with saturation, buffer select latch
// and registered write strobe. LAYER_CMD_RX_TKEEP_CHK_EN adds the sticky tkeep error flag.
module layer_cmd_rx_wr
    import layer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              load_start,
    input  logic [3:0]        load_type,
    input  logic              beat,
    input  logic [63:0]       beat_data,
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
    input  logic [7:0]        beat_keep,
    output logic              tkeep_err,
`endif
    output logic [63:0]       buf_wr_data,
    output logic              buf_wr_en,
    output logic [3:0]        buf_wr_sel,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              addr_ovf
);

    localparam logic [ADDR_W-1:0] CNT_MAX = '1;

    logic [3:0]        sel_next;
    logic [3:0]        sel_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic              sat_reg;
    logic [63:0]       data_reg;
    logic              en_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              ovf_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sel
            assign sel_next[gi] = (load_type == SEL_TYPE[gi]);
        end
    endgenerate

    // sat_reg marks that the last location was already written in this load
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            sel_reg  <= '0;
            cnt_reg  <= '0;
            sat_reg  <= 1'b0;
            data_reg <= '0;
            en_reg   <= 1'b0;
            addr_reg <= '0;
            ovf_reg  <= 1'b0;
        end else begin
            en_reg <= 1'b0;
            if (load_start) begin
                sel_reg  <= sel_next;
                cnt_reg  <= '0;
                sat_reg  <= 1'b0;
                addr_reg <= '0;
            end else if (beat) begin
                data_reg <= beat_data;
                addr_reg <= cnt_reg;
                en_reg   <= |sel_reg;
                if (sat_reg) begin
                    ovf_reg <= 1'b1;
                end
                if (cnt_reg == CNT_MAX) begin
                    sat_reg <= 1'b1;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
    logic tkeep_err_reg;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            tkeep_err_reg <= 1'b0;
        end else if (beat && (beat_keep != 8'hFF)) begin
            tkeep_err_reg <= 1'b1;
        end
    end

    assign tkeep_err = tkeep_err_reg;
`endif

    assign buf_wr_data = data_reg;
    assign buf_wr_en   = en_reg;
    assign buf_wr_sel  = sel_reg;
    assign buf_wr_addr = addr_reg;
    assign addr_ovf    = ovf_reg;

endmodule

// File: rtl/layer_cmd_rx.sv
// Accelerator-side command receiver: decodes reg0 command edges, sequences load/conv/read
// phases and pulses task_finish. LAYER_CMD_RX_TKEEP_CHK_EN enables the tkeep_err output.
module layer_cmd_rx
    import layer_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic [31:0]       slave_lite_reg0,
    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tkeep,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [63:0]       buf_wr_data,
    output logic              buf_wr_en,
    output logic [3:0]        buf_wr_sel,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic [23:0]       cmd_info,
    output logic              conv_start,
    input  logic              conv_done,
    output logic              rd_start,
    input  logic              rd_done,
    output logic              addr_ovf,
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
    output logic              tkeep_err,
`endif
    output logic              task_finish
);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  nib_prev_reg;
    logic [23:0] cmd_info_reg;
    logic        conv_start_reg;
    logic        rd_start_reg;
    logic        conv_start_next;
    logic        rd_start_next;
    logic        load_start;
    logic        info_latch;
    logic [3:0]  cmd_nib;
    logic        cmd_edge;
    logic        beat;

    assign cmd_nib  = slave_lite_reg0[3:0];
    assign cmd_edge = (cmd_nib != 4'h0) && (nib_prev_reg == 4'h0);
    assign beat     = s_axis_tvalid && s_axis_tready;

    always_comb begin
        state_next      = state_reg;
        load_start      = 1'b0;
        conv_start_next = 1'b0;
        rd_start_next   = 1'b0;
        info_latch      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_edge) begin
                    case (cmd_nib)
                        CMD_LOAD: begin
                            state_next = ST_LOAD;
                            load_start = 1'b1;
                            info_latch = 1'b1;
                        end
                        CMD_CONV: begin
                            state_next      = ST_CONV;
                            conv_start_next = 1'b1;
                            info_latch      = 1'b1;
                        end
                        CMD_READ: begin
                            state_next    = ST_READ;
                            rd_start_next = 1'b1;
                            info_latch    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: if (beat && s_axis_tlast) state_next = ST_DONE;
            ST_CONV: if (conv_done) state_next = ST_DONE;
            ST_READ: if (rd_done) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The previous nibble is tracked in every state so a level held across a phase never re-fires
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_reg      <= ST_IDLE;
            nib_prev_reg   <= '0;
            cmd_info_reg   <= '0;
            conv_start_reg <= 1'b0;
            rd_start_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            nib_prev_reg   <= cmd_nib;
            conv_start_reg <= conv_start_next;
            rd_start_reg   <= rd_start_next;
            if (info_latch) begin
                cmd_info_reg <= slave_lite_reg0[31:8];
            end
        end
    end

    layer_cmd_rx_wr #(
        .ADDR_W (ADDR_W)
    ) u_wr (
        .sclk        (sclk),
        .s_rst_n     (s_rst_n),
        .load_start  (load_start),
        .load_type   (slave_lite_reg0[7:4]),
        .beat        (beat),
        .beat_data   (s_axis_tdata),
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
        .beat_keep   (s_axis_tkeep),
        .tkeep_err   (tkeep_err),
`endif
        .buf_wr_data (buf_wr_data),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_sel  (buf_wr_sel),
        .buf_wr_addr (buf_wr_addr),
        .addr_ovf    (addr_ovf)
    );

`ifndef LAYER_CMD_RX_TKEEP_CHK_EN
    logic unused_tkeep;
    assign unused_tkeep = ^s_axis_tkeep;
`endif

    assign s_axis_tready = (state_reg == ST_LOAD);
    assign task_finish   = (state_reg == ST_DONE);
    assign cmd_info      = cmd_info_reg;
    assign conv_start    = conv_start_reg;
    assign rd_start      = rd_start_reg;

endmodule

// File: tb/tb_layer_cmd_rx.sv
// Randomized bench for layer_cmd_rx: a 12-bit and a 2-bit address instance share all stimulus
// and are checked against transaction-level expectations built from the command/load rules.
`timescale 1ns/1ps
module tb_layer_cmd_rx;

    logic        sclk = 1'b0;
    logic        s_rst_n;
    logic [31:0] reg0;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tvalid, tlast, conv_done, rd_done;

    logic        tready     [2];
    logic [63:0] wr_data    [2];
    logic        wr_en      [2];
    logic [3:0]  wr_sel     [2];
    logic [11:0] wr_addr    [2];
    logic [23:0] cmd_info   [2];
    logic        conv_start [2];
    logic        rd_start   [2];
    logic        ovf        [2];
    logic        tf         [2];
    logic [11:0] addr_big;
    logic [1:0]  addr_small;
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
    logic        tkerr      [2];
`endif

    always #5 sclk = ~sclk;

    assign wr_addr[0] = addr_big;
    assign wr_addr[1] = {10'd0, addr_small};

    layer_cmd_rx #(.ADDR_W(12)) u_dut_big (
        .sclk(sclk), .s_rst_n(s_rst_n), .slave_lite_reg0(reg0),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready[0]), .s_axis_tlast(tlast),
        .buf_wr_data(wr_data[0]), .buf_wr_en(wr_en[0]), .buf_wr_sel(wr_sel[0]),
        .buf_wr_addr(addr_big), .cmd_info(cmd_info[0]), .conv_start(conv_start[0]),
        .conv_done(conv_done), .rd_start(rd_start[0]), .rd_done(rd_done),
        .addr_ovf(ovf[0]),
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
        .tkeep_err(tkerr[0]),
`endif
        .task_finish(tf[0])
    );

    layer_cmd_rx #(.ADDR_W(2)) u_dut_small (
        .sclk(sclk), .s_rst_n(s_rst_n), .slave_lite_reg0(reg0),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready[1]), .s_axis_tlast(tlast),
        .buf_wr_data(wr_data[1]), .buf_wr_en(wr_en[1]), .buf_wr_sel(wr_sel[1]),
        .buf_wr_addr(addr_small), .cmd_info(cmd_info[1]), .conv_start(conv_start[1]),
        .conv_done(conv_done), .rd_start(rd_start[1]), .rd_done(rd_done),
        .addr_ovf(ovf[1]),
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
        .tkeep_err(tkerr[1]),
`endif
        .task_finish(tf[1])
    );

    typedef struct packed {
        logic [63:0] data;
        logic [11:0] addr;
        logic [3:0]  sel;
        logic [31:0] cyc;
    } wr_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    wr_t  wq0[$];
    wr_t  wq1[$];
    logic [63:0] exp_data[$];
    int   tf_cnt[2], tf_cyc[2], cs_cnt[2], cs_cyc[2], rs_cnt[2], rs_cyc[2], trdy_cnt[2];
    int   hs_last_cyc;
    int   bad_keep_idx = -1;
    logic ovf_exp[2];

    always @(posedge sclk) cyc <= cyc + 1;

    // Observation side: log writes and pulses with the cycle they were seen in
    always @(negedge sclk) begin
        for (int d = 0; d < 2; d++) begin
            if (wr_en[d]) begin
                if (d == 0) wq0.push_back({wr_data[d], wr_addr[d], wr_sel[d], cyc});
                else        wq1.push_back({wr_data[d], wr_addr[d], wr_sel[d], cyc});
            end
            if (tf[d])         begin tf_cnt[d]++; tf_cyc[d] = cyc; end
            if (conv_start[d]) begin cs_cnt[d]++; cs_cyc[d] = cyc; end
            if (rd_start[d])   begin rs_cnt[d]++; rs_cyc[d] = cyc; end
            if (tready[d])     trdy_cnt[d]++;
        end
        if (tvalid && tready[0] && tlast) hs_last_cyc = cyc;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge sclk);
            #1;
        end
    endtask

    task automatic clear_mon();
        wq0.delete();
        wq1.delete();
        exp_data.delete();
        for (int d = 0; d < 2; d++) begin
            tf_cnt[d] = 0; tf_cyc[d] = -1; cs_cnt[d] = 0; cs_cyc[d] = -1;
            rs_cnt[d] = 0; rs_cyc[d] = -1; trdy_cnt[d] = 0;
        end
        hs_last_cyc = -100;
    endtask

    function automatic logic [3:0] sel_of(input logic [3:0] typ);
        case (typ)
            4'd2:    return 4'b0001;
            4'd3:    return 4'b0010;
            4'd5:    return 4'b0100;
            4'd4:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // mode 0: back-to-back, 1: one idle cycle before each beat, 2: random 0..2 idle cycles
    task automatic send_beats(input int n, input int mode, input bit with_last);
        int  gaps;
        int  budget;
        bit  ok;
        for (int i = 0; i < n; i++) begin
            gaps = (mode == 0) ? 0 : ((mode == 1) ? 1 : $urandom_range(0, 2));
            tvalid = 1'b0;
            tick(gaps);
            tdata  = {$urandom, $urandom};
            tkeep  = (i == bad_keep_idx) ? 8'h0F : 8'hFF;
            tlast  = with_last && (i == n - 1);
            tvalid = 1'b1;
            exp_data.push_back(tdata);
            budget = 0;
            ok     = 1'b0;
            while (!ok && budget < 50) begin
                @(negedge sclk);
                ok = tready[0];
                @(posedge sclk);
                #1;
                budget++;
            end
            if (!ok) check_val("beat_timeout", 64'd0, 64'd1);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tkeep  = 8'hFF;
    endtask

    task automatic wait_tf();
        for (int k = 0; k < 40 && tf_cnt[0] == 0; k++) tick(1);
    endtask

    task automatic check_load(input string nm, input logic [3:0] typ, input int n);
        logic [3:0]  es;
        logic [11:0] ea;
        int          nw, aw, qs;
        wr_t         w;
        es = sel_of(typ);
        nw = (es == 4'b0000) ? 0 : n;
        for (int d = 0; d < 2; d++) begin
            aw = (d == 0) ? 12 : 2;
            if (es != 4'b0000 && n > (1 << aw)) ovf_exp[d] = 1'b1;
            qs = (d == 0) ? wq0.size() : wq1.size();
            check_val($sformatf("%s_d%0d_nwr", nm, d), qs, nw);
            for (int i = 0; i < nw && i < qs; i++) begin
                if (d == 0) w = wq0[i];
                else        w = wq1[i];
                ea = (i < (1 << aw)) ? 12'(i) : 12'((1 << aw) - 1);
                check_val($sformatf("%s_d%0d_addr%0d", nm, d, i), w.addr, ea);
                check_val($sformatf("%s_d%0d_data%0d", nm, d, i), w.data, exp_data[i]);
                check_val($sformatf("%s_d%0d_sel%0d", nm, d, i), w.sel, es);
                if (i == nw - 1) check_val($sformatf("%s_d%0d_lastwr_cyc", nm, d), w.cyc, tf_cyc[d]);
            end
            check_val($sformatf("%s_d%0d_tf_cnt", nm, d), tf_cnt[d], 1);
            check_val($sformatf("%s_d%0d_tf_cyc", nm, d), tf_cyc[d], hs_last_cyc + 1);
            check_val($sformatf("%s_d%0d_ovf", nm, d), ovf[d], ovf_exp[d]);
        end
    endtask

    task automatic run_load(input string nm, input logic [3:0] typ, input int n, input int mode,
                            input int hold, input logic [23:0] info);
        clear_mon();
        reg0 = {info, typ, 4'h1};
        tick(hold);
        reg0[3:0] = 4'h0;
        send_beats(n, mode, 1'b1);
        wait_tf();
        tick(2);
        check_load(nm, typ, n);
        for (int d = 0; d < 2; d++) check_val($sformatf("%s_d%0d_info", nm, d), cmd_info[d], info);
        $display("load %s type=%0d beats=%0d mode=%0d", nm, typ, n, mode);
    endtask

    task automatic run_op(input string nm, input logic [31:0] val, input int dly);
        int  c0;
        bit  is_conv;
        is_conv = (val[3:0] == 4'h4);
        clear_mon();
        reg0 = val;
        c0   = cyc;
        tick(1);
        reg0[3:0] = 4'h0;
        tick(dly);
        if (is_conv) conv_done = 1'b1;
        else         rd_done   = 1'b1;
        tick(1);
        conv_done = 1'b0;
        rd_done   = 1'b0;
        tick(2);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("%s_d%0d_start_cnt", nm, d), is_conv ? cs_cnt[d] : rs_cnt[d], 1);
            check_val($sformatf("%s_d%0d_start_cyc", nm, d), is_conv ? cs_cyc[d] : rs_cyc[d], c0 + 1);
            check_val($sformatf("%s_d%0d_other_start", nm, d), is_conv ? rs_cnt[d] : cs_cnt[d], 0);
            check_val($sformatf("%s_d%0d_tf_cnt", nm, d), tf_cnt[d], 1);
            check_val($sformatf("%s_d%0d_tf_cyc", nm, d), tf_cyc[d], c0 + 2 + dly);
            check_val($sformatf("%s_d%0d_info", nm, d), cmd_info[d], val[31:8]);
            check_val($sformatf("%s_d%0d_tready", nm, d), trdy_cnt[d], 0);
        end
        $display("op %s reg0=%08h done_delay=%0d", nm, val, dly);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0]  tt [5];
        logic [3:0]  typ;
        logic [31:0] r;
        int          k, n;
        tt = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
        s_rst_n = 1'b0; reg0 = '0; tdata = '0; tkeep = 8'hFF;
        tvalid = 1'b0; tlast = 1'b0; conv_done = 1'b0; rd_done = 1'b0;
        ovf_exp[0] = 1'b0; ovf_exp[1] = 1'b0;
        clear_mon();
        tick(3);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("rst_d%0d_tready", d), tready[d], 0);
            check_val($sformatf("rst_d%0d_wr_en", d), wr_en[d], 0);
            check_val($sformatf("rst_d%0d_sel", d), wr_sel[d], 0);
            check_val($sformatf("rst_d%0d_addr", d), wr_addr[d], 0);
            check_val($sformatf("rst_d%0d_data", d), wr_data[d], 0);
            check_val($sformatf("rst_d%0d_info", d), cmd_info[d], 0);
            check_val($sformatf("rst_d%0d_cs", d), conv_start[d], 0);
            check_val($sformatf("rst_d%0d_rs", d), rd_start[d], 0);
            check_val($sformatf("rst_d%0d_ovf", d), ovf[d], 0);
            check_val($sformatf("rst_d%0d_tf", d), tf[d], 0);
`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
            check_val($sformatf("rst_d%0d_tkerr", d), tkerr[d], 0);
`endif
        end
        s_rst_n = 1'b1;
        tick(2);

        run_load("bias4", 4'd2, 4, 0, 1, 24'h0);
        run_load("weight6", 4'd5, 6, 1, 1, 24'h0);
        run_op("conv", 32'h0019_4044, 4);
        run_op("read0", 32'h00AB_CD02, 0);

        // Unsupported command code: nothing starts, nothing finishes
        clear_mon();
        reg0 = 32'h0000_0008;
        tick(3);
        reg0 = 32'h0;
        tick(2);
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("bogus_d%0d_tf", d), tf_cnt[d], 0);
            check_val($sformatf("bogus_d%0d_starts", d), cs_cnt[d] + rs_cnt[d], 0);
            check_val($sformatf("bogus_d%0d_tready", d), trdy_cnt[d], 0);
        end
        $display("op bogus reg0=00000008");

        // Held level accepted once; a CONV edge in the middle of the load is ignored
        clear_mon();
        reg0 = 32'h0000_0021;
        tick(10);
        send_beats(2, 0, 1'b0);
        reg0 = 32'h0;
        tick(1);
        reg0 = 32'h0000_0004;
        tick(2);
        reg0 = 32'h0;
        send_beats(3, 0, 1'b1);
        wait_tf();
        tick(3);
        check_load("hold", 4'd2, 5);
        for (int d = 0; d < 2; d++) check_val($sformatf("hold_d%0d_cs", d), cs_cnt[d], 0);
        $display("load hold type=2 beats=5 with ignored conv edge");

        for (int it = 0; it < 24; it++) begin
            k = $urandom_range(0, 3);
            r = $urandom;
            if (k < 2) begin
                typ = tt[$urandom_range(0, 4)];
                n   = (typ == 4'd7) ? $urandom_range(1, 4) : $urandom_range(1, 8);
                run_load($sformatf("rnd%0d", it), typ, n, 2, $urandom_range(1, 3), r[23:0]);
            end else begin
                r[3:0] = (k == 2) ? 4'h4 : 4'h2;
                run_op($sformatf("rnd%0d", it), r, $urandom_range(0, 5));
            end
        end

`ifdef LAYER_CMD_RX_TKEEP_CHK_EN
        bad_keep_idx = 1;
        run_load("tkeep", 4'd4, 3, 0, 1, 24'h5);
        bad_keep_idx = -1;
        for (int d = 0; d < 2; d++) check_val($sformatf("tkeep_d%0d_err", d), tkerr[d], 1);
`endif

        // Asynchronous reset while beat 2 of a load is on the bus
        clear_mon();
        reg0 = 32'h0000_0021;
        tick(1);
        reg0 = 32'h0;
        send_beats(2, 0, 1'b0);
        tdata  = 64'hDEAD_BEEF_0000_0002;
        tvalid = 1'b1;
        for (int d = 0; d < 2; d++) check_val($sformatf("prerst_d%0d_wr_en", d), wr_en[d], 1);
        #2 s_rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check_val($sformatf("midrst_d%0d_tready", d), tready[d], 0);
            check_val($sformatf("midrst_d%0d_wr_en", d), wr_en[d], 0);
            check_val($sformatf("midrst_d%0d_tf", d), tf[d], 0);
            check_val($sformatf("midrst_d%0d_ovf", d), ovf[d], 0);
        end
        tvalid = 1'b0;
        tick(2);
        s_rst_n = 1'b1;
        ovf_exp[0] = 1'b0;
        ovf_exp[1] = 1'b0;
        tick(1);
        $display("reset during load beat 2");
        run_load("postrst", 4'd3, 3, 0, 1, 24'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_cmd_rx.md
Name: layer_cmd_rx

Overview:
Accelerator-side counterpart of the per-layer test driver. Decodes the command nibble of lite register 0 and accepts the MM2S AXI-Stream as the slave end. Each stream beat is routed to one of four on-chip buffers (bias, leakyrelu, weight, feature). The block then reports `task_finish` back to the driver at the end of every load, convolution or read-back phase.

Parameters:
- ADDR_W, 12, width of the buffer write address (per-buffer beat index).
- CMD_LOAD, 4'h1, reg0[3:0] code meaning "start stream load".
- CMD_READ, 4'h2, reg0[3:0] code meaning "start DMA read-back".
- CMD_CONV, 4'h4, reg0[3:0] code meaning "start convolution".

Ports:
- sclk  in  1  system clock
- s_rst_n  in  1  reset, asynchronous, active-low
- slave_lite_reg0  in  32  [3:0] command code, [7:4] load type (2 bias, 3 leakyrelu, 5 weight, 4 feature), [31:8] batch info
- s_axis_tdata  in  64  stream data
- s_axis_tkeep  in  8  byte enables (expected 8'hFF)
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  last beat of the load
- buf_wr_data  out  64  write data to the selected buffer
- buf_wr_en  out  1  buffer write strobe
- buf_wr_sel  out  4  one-hot select: [0] bias, [1] leakyrelu, [2] weight, [3] feature
- buf_wr_addr  out  ADDR_W  beat index within the current load
- cmd_info  out  24  reg0[31:8] latched at command accept
- conv_start  out  1  one-cycle pulse to the conv engine
- conv_done  in  1  conv engine completion pulse
- rd_start  out  1  one-cycle pulse to the S2MM read-back path
- rd_done  in  1  read-back completion pulse
- addr_ovf  out  1  sticky: a load exceeded 2^ADDR_W beats
- task_finish  out  1  one-cycle completion pulse to the driver

Behaviour:
- Reset values: all outputs 0; state IDLE; the previous-nibble register is 0.
- Command accept:
  - A command is accepted in IDLE only, when reg0[3:0] is nonzero and the previous cycle's reg0[3:0] was 0 (rising detect).
  - A level held for several cycles is accepted once.
  - Any nibble change outside IDLE is ignored.
  - On accept, cmd_info is latched from reg0[31:8].
- States: IDLE, LOAD, CONV, READ, DONE.
- IDLE → LOAD on CMD_LOAD:
  - Latch the type and build buf_wr_sel.
  - Unknown type gives sel 4'b0000: data is still consumed but nothing is written.
  - buf_wr_addr is cleared.
- IDLE → CONV on CMD_CONV, with conv_start pulsed in the transition cycle (registered, visible the cycle after the command edge).
- IDLE → READ on CMD_READ, with rd_start pulsed the same way.
- Any other nonzero code in IDLE is ignored and the state stays IDLE.
- LOAD:
  - s_axis_tready = 1 only in LOAD, combinational from state.
  - Each beat with tvalid & tready drives buf_wr_data/buf_wr_en/buf_wr_addr, registered with 1-cycle latency. Address equals the beat index.
  - Address increments per beat and saturates at 2^ADDR_W−1. A beat arriving at the saturated address sets addr_ovf, and that beat overwrites the last location.
  - addr_ovf clears only on reset.
  - A beat with tlast → DONE. The last write and the transition happen in the same cycle.
- CONV → DONE on conv_done. READ → DONE on rd_done. A done pulse arriving in the same cycle as the start pulse is honoured.
- DONE: task_finish = 1 for exactly one cycle, then IDLE.
- A command edge arriving in the DONE cycle is lost; the driver never issues one then.
- buf_wr_en is never asserted outside the cycle after an accepted LOAD beat.
- Reset mid-load: all outputs return to 0 immediately (asynchronous) and the partial load is abandoned.

Optional Feature:
- Macro: LAYER_CMD_RX_TKEEP_CHK_EN.
- With the macro: adds output `tkeep_err` (1 bit, reset 0). It is set sticky on any accepted LOAD beat with s_axis_tkeep != 8'hFF, and such a beat is still written.
- Without the macro: the tkeep_err port and logic are absent and s_axis_tkeep is unused.

Decomposition:
- Shared package (layer_pkg):
  - command code constants CMD_LOAD/CMD_READ/CMD_CONV;
  - type codes TYPE_BIAS=2, TYPE_LEAKY=3, TYPE_FEATURE=4, TYPE_WEIGHT=5;
  - one-hot state localparams (IDLE 5'h01 … DONE 5'h10).
- One natural sub-module: layer_cmd_rx_wr (stream-to-buffer write stage: beat counter, saturation, sel/strobe register). The FSM and command decode stay in the top.

Test Plan:
- reg0 0x21 for 1 cycle, then 0x20; 4 beats D0..D3 with tlast on D3 → buf_wr_sel=4'b0001, addr 0..3, task_finish one cycle after the D3 write.
- Weight load 0x51 with tvalid toggling every other cycle, 6 beats → exactly 6 writes, addr 0..5, sel 4'b0100, no gaps in addressing.
- reg0 0x19_4044 → conv_start pulse, cmd_info=0x194044>>8=0x1940; conv_done 5 cycles later → task_finish the next cycle; tready stays 0 throughout.
- reg0 held at 0x21 for 10 cycles → a single accept; CMD_CONV edge arriving during LOAD is ignored (no conv_start).
- ADDR_W=2, 5-beat load → addr 0,1,2,3,3; addr_ovf=1 after the 5th beat; task_finish still pulses.
- Assert s_rst_n low during beat 2 of a load → tready, buf_wr_en and task_finish drop asynchronously; after release a new 0x31 load starts at addr 0.
